adder_4_err_monitor: RTL

ADDER_4_ERR_MONITOR -- requirements
Module: adder_4_err_monitor

---
 rtl/adder_4_err_monitor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/adder_4_err_monitor.sv
// Error monitor for a 4-bit approximate adder: compares the approximate
// result against the exact sum over NSAMP accepted samples and accumulates
// error count, maximum absolute error, summed absolute error and summed
// Hamming distance.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start after reset; statistics hold
// S_RUN   | accepting samples until NSAMP have been taken
// S_DRAIN | no more acceptance; letting the last sample reach the totals
// S_DONE  | results final and held; start begins a fresh run
module adder_4_err_monitor #(
    parameter int NSAMP = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    input  logic        in_cin,
    input  logic [4:0]  in_approx,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count,
    output logic [4:0]  max_abs_err,
    output logic [20:0] sum_abs_err,
    output logic [18:0] sum_hd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counter value at which the acceptance being taken is the last one.
    localparam logic [15:0] LP_LAST = 16'(NSAMP - 1);

    state_t      r_state;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_count;

    logic        r_s1_valid;
    logic [4:0]  r_s1_abs;
    logic [2:0]  r_s1_hd;

    logic [15:0] r_err_count;
    logic [4:0]  r_max_abs_err;
    logic [20:0] r_sum_abs_err;
    logic [18:0] r_sum_hd;

    logic        w_accept;
    logic        w_clear;
    logic [4:0]  w_exact;
    logic [4:0]  w_abs;
    logic [4:0]  w_diff;
    logic [2:0]  w_hd;

    assign w_accept = in_valid & r_in_ready;
    assign w_clear  = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    // Exact reference sum, absolute error and bitwise distance of the current sample.
    always_comb begin
        w_exact = {1'b0, in_a} + {1'b0, in_b} + {4'b0000, in_cin};
        w_abs   = (in_approx >= w_exact) ? (in_approx - w_exact) : (w_exact - in_approx);
        w_diff  = in_approx ^ w_exact;
        w_hd    = {2'b00, w_diff[0]} + {2'b00, w_diff[1]} + {2'b00, w_diff[2]}
                + {2'b00, w_diff[3]} + {2'b00, w_diff[4]};
    end

    // Run sequencing: sample counting, drain and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_count    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_count <= r_count + 16'd1;
                        if (r_count == LP_LAST) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Stage 1 empties one edge into the drain; the totals are final one edge later.
                    if (!r_s1_valid) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture per-sample error metrics at the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_abs   <= '0;
            r_s1_hd    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_abs <= w_abs;
                r_s1_hd  <= w_hd;
            end
        end
    end

    // Stage 2: fold stage-1 metrics into the running statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count   <= '0;
            r_max_abs_err <= '0;
            r_sum_abs_err <= '0;
            r_sum_hd      <= '0;
        end else if (w_clear) begin
            r_err_count   <= '0;
            r_max_abs_err <= '0;
            r_sum_abs_err <= '0;
            r_sum_hd      <= '0;
        end else if (r_s1_valid) begin
            if (r_s1_abs != 5'd0) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (r_s1_abs > r_max_abs_err) begin
                r_max_abs_err <= r_s1_abs;
            end
            r_sum_abs_err <= r_sum_abs_err + {16'd0, r_s1_abs};
            r_sum_hd      <= r_sum_hd + {16'd0, r_s1_hd};
        end
    end

    assign in_ready    = r_in_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_count   = r_err_count;
    assign max_abs_err = r_max_abs_err;
    assign sum_abs_err = r_sum_abs_err;
    assign sum_hd      = r_sum_hd;

endmodule
